// File: rtl/store_buffer.sv
// store_buffer: FIFO store buffer with same-word store merging and load forwarding
module store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int MERGE  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [DATA_W/8-1:0]        st_be,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W/8-1:0]        ld_be,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_stall,
  output logic                       mem_wen,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_dout,
  output logic [DATA_W/8-1:0]        mem_be,
  input  logic                       mem_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int BW  = DATA_W / 8;
  localparam int OFF = $clog2(BW);
  localparam int AW  = $clog2(DEPTH);
  localparam int WA  = ADDR_W - OFF;
  logic [WA-1:0]     r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [BW-1:0]     r_be   [DEPTH];
  logic [AW-1:0]     r_head, r_tail;
  logic [AW:0]       r_count;
  logic [AW-1:0]     w_young, w_idx;
  logic              w_merge, w_push, w_pop, w_found, w_unused;
  logic [BW-1:0]     w_mbe;
  logic [DATA_W-1:0] w_mdata;
  assign w_young  = r_tail - 1'b1;
  assign w_merge  = MERGE != 0 && st_valid && r_count >= 2 && r_addr[w_young] == st_addr[ADDR_W-1:OFF];
  assign empty    = r_count == 0;
  assign full     = r_count == (AW+1)'(DEPTH);
  assign w_push   = st_valid && !w_merge && !full;
  assign w_pop    = !empty && mem_ack;
  assign st_ready = w_merge || !full;
  assign count    = r_count;
  assign mem_wen  = !empty;
  assign mem_addr = ADDR_W'(r_addr[r_head]) << OFF;
  assign mem_dout = r_data[r_head];
  assign mem_be   = r_be[r_head];
  assign w_unused = ^{st_addr[OFF-1:0], ld_addr[OFF-1:0]};
  // scan oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    w_found = 1'b0;
    w_mbe   = '0;
    w_mdata = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + AW'(i);
      if ((AW+1)'(i) < r_count && r_addr[w_idx] == ld_addr[ADDR_W-1:OFF]) begin
        w_found = 1'b1;
        w_mbe   = r_be[w_idx];
        w_mdata = r_data[w_idx];
      end
    end
  end
  assign ld_hit   = ld_valid && w_found && (w_mbe & ld_be) == ld_be;
  assign ld_stall = ld_valid && w_found && !ld_hit;
  assign ld_data  = ld_hit ? w_mdata : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_be[i] <= '0;
    end else begin
      if (w_push) begin
        r_addr[r_tail] <= st_addr[ADDR_W-1:OFF];
        r_data[r_tail] <= st_data;
        r_be[r_tail]   <= st_be;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_merge) begin
        for (int b = 0; b < BW; b++)
          if (st_be[b]) r_data[w_young][8*b +: 8] <= st_data[8*b +: 8];
        r_be[w_young] <= r_be[w_young] | st_be;
      end
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-model checked bench for store_buffer (MERGE=1 and MERGE=0 instances)
module tb_store_buffer;
  typedef struct {logic [31:0] a; logic [31:0] d; logic [3:0] be;} ent_t;
  typedef struct {logic hit; logic stall; logic [31:0] data;} ld_t;
  logic clk = 0, rst_n = 0;
  logic st_valid = 0, ld_valid = 0, mem_ack = 0;
  logic [31:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [3:0] st_be = 0, ld_be = 0;
  logic st_ready, ld_hit, ld_stall, mem_wen, empty, full;
  logic [31:0] ld_data, mem_addr, mem_dout;
  logic [3:0] mem_be;
  logic [2:0] count;
  logic st_ready_n, ld_hit_n, ld_stall_n, mem_wen_n, empty_n, full_n;
  logic [31:0] ld_data_n, mem_addr_n, mem_dout_n;
  logic [3:0] mem_be_n;
  logic [2:0] count_n;
  ent_t q1[$], q0[$];
  bit chk_en = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  store_buffer #(.MERGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_be(mem_be), .mem_ack(mem_ack),
    .count(count), .empty(empty), .full(full));
  store_buffer #(.MERGE(0)) u_nm (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_ready(st_ready_n), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_hit(ld_hit_n), .ld_data(ld_data_n), .ld_stall(ld_stall_n), .mem_wen(mem_wen_n),
    .mem_addr(mem_addr_n), .mem_dout(mem_dout_n), .mem_be(mem_be_n), .mem_ack(mem_ack),
    .count(count_n), .empty(empty_n), .full(full_n));
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
    end
  endtask
  function automatic bit will_merge();
    return q1.size() >= 2 && st_valid && q1[q1.size()-1].a == (st_addr & ~32'h3);
  endfunction
  function automatic ld_t lookup(input bit nm);
    ld_t r = '{0, 0, 0};
    ent_t e;
    bit f = 0;
    int n = nm ? q0.size() : q1.size();
    for (int i = n - 1; i >= 0 && !f; i--) begin
      e = nm ? q0[i] : q1[i];
      f = e.a == (ld_addr & ~32'h3);
    end
    if (ld_valid && f) begin
      r.hit = (e.be & ld_be) == ld_be;
      r.stall = !r.hit;
      r.data = r.hit ? e.d : 0;
    end
    return r;
  endfunction
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      q1.delete();
      q0.delete();
      chk_en = 1;
    end else begin
      automatic bit mg = will_merge();
      automatic bit p1 = st_valid && !mg && q1.size() < 4;
      automatic bit p0 = st_valid && q0.size() < 4;
      automatic ent_t ne = '{st_addr & ~32'h3, st_data, st_be};
      if (mg) begin
        automatic ent_t y = q1[q1.size()-1];
        for (int b = 0; b < 4; b++) if (st_be[b]) y.d[8*b +: 8] = st_data[8*b +: 8];
        y.be = y.be | st_be;
        q1[q1.size()-1] = y;
      end
      if (mem_ack && q1.size() > 0) void'(q1.pop_front());
      if (mem_ack && q0.size() > 0) void'(q0.pop_front());
      if (p1) q1.push_back(ne);
      if (p0) q0.push_back(ne);
    end
  end
  always @(negedge clk) if (chk_en) begin
    automatic ld_t e1 = lookup(0);
    automatic ld_t e0 = lookup(1);
    chk("count", count, q1.size());
    chk("empty", empty, q1.size() == 0);
    chk("full", full, q1.size() == 4);
    chk("mem_wen", mem_wen, q1.size() != 0);
    chk("st_ready", st_ready, will_merge() || q1.size() < 4);
    chk("ld_hit", ld_hit, e1.hit);
    chk("ld_stall", ld_stall, e1.stall);
    chk("ld_data", ld_data, e1.data);
    if (q1.size() != 0) begin
      chk("mem_addr", mem_addr, q1[0].a);
      chk("mem_dout", mem_dout, q1[0].d);
      chk("mem_be", mem_be, q1[0].be);
    end
    chk("nm_count", count_n, q0.size());
    chk("nm_st_ready", st_ready_n, q0.size() < 4);
    chk("nm_ld_hit", ld_hit_n, e0.hit);
    chk("nm_ld_stall", ld_stall_n, e0.stall);
    chk("nm_ld_data", ld_data_n, e0.data);
    if (q0.size() != 0) chk("nm_mem_addr", mem_addr_n, q0[0].a);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    st_valid = v;
    st_addr = a;
    st_data = d;
    st_be = be;
  endtask
  task automatic drain();
    int n = 0;
    st(0, 0, 0, 0);
    mem_ack = 1;
    while ((!empty || !empty_n) && n < 20) begin
      cyc();
      n++;
    end
    mem_ack = 0;
    #1;
    chk("drain_done", {empty, empty_n}, 2'b11);
  endtask
  initial begin
    cyc();
    cyc();
    rst_n = 1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_hit_stall", {ld_hit, ld_stall}, 0);
    chk("rst_count", count, 0);
    st(1, 32'h0, 32'hA0, 4'hF); cyc();
    st(1, 32'h4, 32'hA4, 4'hF); cyc();
    st(1, 32'h8, 32'hA8, 4'hF); cyc();
    st(1, 32'hC, 32'hAC, 4'hF); cyc();
    st(1, 32'h10, 32'hB0, 4'hF);
    #1;
    chk("fill_full", full, 1);
    chk("fill_refuse", st_ready, 0);
    cyc();
    chk("refused_count", count, 4);
    st(1, 32'hE, 32'hEE000000, 4'hC);
    #1;
    chk("fullmerge_ready", st_ready, 1);
    cyc();
    st(0, 0, 0, 0);
    #1;
    chk("fullmerge_count", count, 4);
    chk("head_addr", mem_addr, 32'h0);
    mem_ack = 1;
    cyc();
    mem_ack = 0;
    #1;
    chk("pop_count", count, 3);
    chk("pop_next_addr", mem_addr, 32'h4);
    drain();
    st(1, 32'h100, 32'h0000BBAA, 4'h3); cyc();
    st(1, 32'h104, 32'h11223344, 4'hF); cyc();
    st(1, 32'h106, 32'hDDCC0000, 4'hC); cyc();
    st(0, 0, 0, 0);
    ld_valid = 1;
    ld_addr = 32'h104;
    ld_be = 4'hF;
    #1;
    chk("merge_count", count, 2);
    chk("nomerge_count", count_n, 3);
    chk("merge_hit", ld_hit, 1);
    chk("merge_data", ld_data, 32'hDDCC3344);
    ld_valid = 0;
    drain();
    st(1, 32'h40, 32'h0, 4'hF); cyc();
    st(1, 32'h20, 32'h12345678, 4'hF); cyc();
    st(1, 32'h20, 32'h000000EF, 4'h1);
    ld_valid = 1;
    ld_addr = 32'h20;
    ld_be = 4'h1;
    #1;
    chk("same_cycle_invisible", ld_data, 32'h12345678);
    cyc();
    st(0, 0, 0, 0);
    #1;
    chk("fwd_hit", ld_hit, 1);
    chk("fwd_data", ld_data, 32'h123456EF);
    chk("fwd_nm_data", ld_data_n, 32'h000000EF);
    ld_be = 4'hF;
    #1;
    chk("fwd_full_hit", ld_hit, 1);
    chk("fwd_nm_stall", {ld_stall_n, ld_hit_n}, 2'b10);
    st(1, 32'h60, 32'h66, 4'hF);
    mem_ack = 1;
    ld_addr = 32'h60;
    #1;
    chk("push_not_visible", ld_hit, 0);
    chk("simul_head", mem_addr, 32'h40);
    cyc();
    st(0, 0, 0, 0);
    mem_ack = 0;
    #1;
    chk("simul_count", count, 2);
    chk("simul_head2", mem_addr, 32'h20);
    chk("push_visible", ld_data, 32'h66);
    mem_ack = 1;
    cyc();
    mem_ack = 0;
    #1;
    chk("order_head3", mem_addr, 32'h60);
    chk("order_count", count, 1);
    ld_valid = 0;
    st(1, 32'h70, 32'h7, 4'hF); cyc();
    st(1, 32'h74, 32'h8, 4'hF); cyc();
    st(0, 0, 0, 0);
    #1;
    chk("pre_rst_count", {count, mem_wen}, {3'd3, 1'b1});
    rst_n = 0;
    mem_ack = 1;
    cyc();
    rst_n = 1;
    mem_ack = 0;
    #1;
    chk("midrst_state", {count, mem_wen, empty}, {3'd0, 1'b0, 1'b1});
    repeat (3000) begin
      rst_n = $urandom_range(0, 99) != 0;
      st($urandom_range(0, 9) < 6, $urandom_range(0, 31), $urandom, 4'($urandom));
      mem_ack = $urandom_range(0, 9) < 3;
      ld_valid = $urandom_range(0, 1);
      ld_addr = $urandom_range(0, 31);
      ld_be = 4'($urandom);
      cyc();
    end
    st(0, 0, 0, 0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_W, default 32, data width; a multiple of 8.
- ADDR_W, default 32, byte-address width.
- DEPTH, default 4, number of entries; a power of 2, at least 2.
- MERGE, default 1, enables coalescing of consecutive stores to the same word.

REQ-002 The block SHALL expose these ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- st_valid  in  1  store request from the MEM stage.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data, lane-aligned.
- st_be  in  DATA_W/8  store byte enables.
- st_ready  out  1  store accepted this cycle when asserted together with st_valid.
- ld_valid  in  1  load lookup request.
- ld_addr  in  ADDR_W  load byte address.
- ld_be  in  DATA_W/8  bytes the load needs.
- ld_hit  out  1  forwarded data valid.
- ld_data  out  DATA_W  forwarded data.
- ld_stall  out  1  partial overlap; the pipeline must hold the load.
- mem_wen  out  1  write request to the cache.
- mem_addr  out  ADDR_W  write word address, low log2(DATA_W/8) bits zero.
- mem_dout  out  DATA_W  write data.
- mem_be  out  DATA_W/8  write byte enables.
- mem_ack  in  1  cache accepted the head entry.
- count  out  log2(DEPTH)+1  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

Function
REQ-003 Storage SHALL be a circular FIFO of DEPTH entries {word address, data, be}; head = oldest, tail = next free; pointers wrap from DEPTH-1 to 0.
REQ-004 Word address SHALL be addr[ADDR_W-1:log2(DATA_W/8)]; all matching SHALL use word address only.
REQ-005 Merge condition SHALL be: MERGE=1, st_valid=1, count>=2, and youngest entry word address == st_addr word address.
REQ-006 On a merge, the youngest entry SHALL be updated per lane where st_be=1 (data lane replaced, be bit set); count unchanged.
REQ-007 Push condition SHALL be: st_valid=1, merge condition false, full=0; on push a new entry SHALL be written at tail and tail incremented.
REQ-008 st_ready SHALL be combinational: 1 if the merge condition holds (even when full=1), else !full.
REQ-009 The head entry SHALL never be merged into (count>=2 rule), so mem_* stays stable while mem_wen=1.
REQ-010 mem_wen SHALL equal !empty; mem_addr/mem_dout/mem_be SHALL reflect the head entry and stay stable until pop.
REQ-011 Pop SHALL occur on a rising edge with mem_wen=1 and mem_ack=1; mem_ack with mem_wen=0 SHALL be ignored.
REQ-012 Push and pop in the same cycle SHALL leave count unchanged; merge and pop in the same cycle SHALL decrement count by 1.
REQ-013 Load lookup SHALL be combinational over all valid entries, including the head being popped this cycle; the youngest matching entry wins.
REQ-014 If ld_valid=1, a match exists, and (match.be & ld_be)==ld_be, then ld_hit=1 and ld_data=match data; ld_stall=0.
REQ-015 If ld_valid=1, a match exists, and (match.be & ld_be)!=ld_be, then ld_stall=1 and ld_hit=0.
REQ-016 With no match or ld_valid=0: ld_hit=0, ld_stall=0, and ld_data=0.
REQ-017 A store accepted in cycle N SHALL be visible to loads from cycle N+1; a same-cycle store SHALL NOT be visible.
REQ-018 Minimum latency from store acceptance into an empty buffer to mem_wen=1 SHALL be 1 cycle.

Reset
REQ-019 When rst_n=0 at a rising edge, head=tail=0, count=0, and all entry be bits are cleared.
REQ-020 After reset: empty=1, full=0, mem_wen=0, st_ready=1, ld_hit=0, ld_stall=0.
REQ-021 Reset mid-transaction SHALL discard all entries, including an unacknowledged head; mem_ack during reset SHALL be ignored.

Verification
REQ-022 Fill/drain (DEPTH=4): 4 stores to addresses 0x0, 0x4, 0x8, 0xC with be=F and mem_ack=0 -> full=1, st_ready=0; a store to 0x10 SHALL be refused; one mem_ack -> pop of 0x0 and count=3.
REQ-023 Merge: store 0x100/be=3/data=0x0000BBAA, then store 0x104/be=F, then store 0x106/be=C/data=0xDDCC0000 -> count=2 and entry 0x104 be=F with bytes [3:2]=DD,CC; with MERGE=0, count=3.
REQ-024 Full-merge: with the buffer full and youngest entry 0xC, a store to 0xE with be=C SHALL give st_ready=1 and count stays 4.
REQ-025 Forwarding: with entry 0x20/be=F/data=0x12345678 and a younger 0x20/be=1/data=0xEF, a load at 0x20 with be=1 -> ld_hit=1 and ld_data[7:0]=0xEF (merged case); a load with be=F on an entry holding be=1 only -> ld_stall=1.
REQ-026 Simultaneous: with count=2, push and mem_ack in the same cycle -> count=2 and FIFO order preserved on the cache port.
REQ-027 Reset: rst_n=0 with count=3 and mem_wen=1 -> next cycle count=0, mem_wen=0, empty=1.
